// File: rtl/wb_stage.sv
// wb_stage: writeback stage of the five-stage MIPS pipeline.
//
// This stage sits on the consumer side of the MEM/WB pipeline register.
// It picks the GPR write data (HI/LO, load data or ALU result) and decides
// whether the write commits. Conditional moves (MOVN/MOVZ) and writes to $0
// never commit. The commit is registered onto the RF write port.
// The stage also owns the architectural HI/LO registers. It keeps a
// two-entry history of committed writes, which decode uses for forwarding.
//
// Ports:
//   Clk, Rst_n                     clock, asynchronous active-low reset
//   RegWriteIn, MoveNotZeroIn,     write/conditional-move control
//   DontMoveIn, ZeroIn
//   HiOrLoIn, MemToRegIn,          write-data select
//   HiLoToRegIn
//   HiLoWriteIn, RHiIn, RLoIn      HI/LO load strobes and values
//   ALUResultIn, ReadDataIn        candidate write data
//   WriteAddressIn                 destination GPR
//   RsAddr, RtAddr                 decode-stage forwarding lookup addresses
//   RFWriteEnable/Address/Data     registered register-file write port
//   HiOut, LoOut                   architectural HI/LO
//   RsHit/RsData, RtHit/RtData     combinational forwarding results
//   WriteCount                     wrapping count of committed GPR writes
module wb_stage #(
  parameter int CountWidth = 16
) (
  input  logic                  Clk,
  input  logic                  Rst_n,
  input  logic                  RegWriteIn,
  input  logic                  MoveNotZeroIn,
  input  logic                  DontMoveIn,
  input  logic                  HiOrLoIn,
  input  logic                  MemToRegIn,
  input  logic                  HiLoToRegIn,
  input  logic [1:0]            HiLoWriteIn,
  input  logic [31:0]           RHiIn,
  input  logic [31:0]           RLoIn,
  input  logic [31:0]           ZeroIn,
  input  logic [31:0]           ALUResultIn,
  input  logic [31:0]           ReadDataIn,
  input  logic [4:0]            WriteAddressIn,
  input  logic [4:0]            RsAddr,
  input  logic [4:0]            RtAddr,
  output logic                  RFWriteEnable,
  output logic [4:0]            RFWriteAddress,
  output logic [31:0]           RFWriteData,
  output logic [31:0]           HiOut,
  output logic [31:0]           LoOut,
  output logic                  RsHit,
  output logic                  RtHit,
  output logic [31:0]           RsData,
  output logic [31:0]           RtData,
  output logic [CountWidth-1:0] WriteCount
);

  logic                  rf_en_reg;
  logic [4:0]            rf_addr_reg;
  logic [31:0]           rf_data_reg;
  logic [31:0]           hi_reg;
  logic [31:0]           lo_reg;
  logic [CountWidth-1:0] count_reg;

  // History: e0 is the newest committed write, e1 the one before it.
  logic                  e0_valid_reg, e1_valid_reg;
  logic [4:0]            e0_addr_reg,  e1_addr_reg;
  logic [31:0]           e0_data_reg,  e1_data_reg;

  logic [31:0]           sel_data;
  logic                  move_ok;
  logic                  commit;

  // HI/LO reads use the current register values. A same-cycle HI/LO load
  // only becomes visible to mfhi/mflo from the next instruction.
  always_comb begin
    sel_data = ALUResultIn;
    if (HiLoToRegIn) begin
      sel_data = HiOrLoIn ? hi_reg : lo_reg;
    end else if (MemToRegIn) begin
      sel_data = ReadDataIn;
    end
  end

  assign move_ok = DontMoveIn | (MoveNotZeroIn ? (|ZeroIn) : ~(|ZeroIn));
  assign commit  = RegWriteIn & (|WriteAddressIn) & move_ok;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      rf_en_reg   <= 1'b0;
      rf_addr_reg <= 5'd0;
      rf_data_reg <= 32'd0;
      count_reg   <= '0;
    end else begin
      rf_en_reg <= commit;
      if (commit) begin
        rf_addr_reg <= WriteAddressIn;
        rf_data_reg <= sel_data;
        count_reg   <= count_reg + CountWidth'(1);
      end
    end
  end

  // HI/LO loads are driven by the multiply/divide path and do not depend
  // on whether the GPR write commits.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      hi_reg <= 32'd0;
      lo_reg <= 32'd0;
    end else begin
      if (HiLoWriteIn[1]) hi_reg <= RHiIn;
      if (HiLoWriteIn[0]) lo_reg <= RLoIn;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      e0_valid_reg <= 1'b0;
      e0_addr_reg  <= 5'd0;
      e0_data_reg  <= 32'd0;
      e1_valid_reg <= 1'b0;
      e1_addr_reg  <= 5'd0;
      e1_data_reg  <= 32'd0;
    end else if (commit) begin
      e1_valid_reg <= e0_valid_reg;
      e1_addr_reg  <= e0_addr_reg;
      e1_data_reg  <= e0_data_reg;
      e0_valid_reg <= 1'b1;
      e0_addr_reg  <= WriteAddressIn;
      e0_data_reg  <= sel_data;
    end
  end

  // One lookup per source operand (gi = 0: rs, gi = 1: rt).
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_lookup
      logic [4:0]  addr_c;
      logic        hit_c;
      logic [31:0] data_c;

      assign addr_c = (gi == 0) ? RsAddr : RtAddr;

      // e0 is tested last so that the newer write overrides e1 when both
      // entries hold the same address.
      always_comb begin
        hit_c  = 1'b0;
        data_c = 32'd0;
        if (addr_c != 5'd0) begin
          if (e1_valid_reg && (e1_addr_reg == addr_c)) begin
            hit_c  = 1'b1;
            data_c = e1_data_reg;
          end
          if (e0_valid_reg && (e0_addr_reg == addr_c)) begin
            hit_c  = 1'b1;
            data_c = e0_data_reg;
          end
        end
      end

      if (gi == 0) begin : g_rs
        assign RsHit  = hit_c;
        assign RsData = data_c;
      end else begin : g_rt
        assign RtHit  = hit_c;
        assign RtData = data_c;
      end
    end
  endgenerate

  assign RFWriteEnable  = rf_en_reg;
  assign RFWriteAddress = rf_addr_reg;
  assign RFWriteData    = rf_data_reg;
  assign HiOut          = hi_reg;
  assign LoOut          = lo_reg;
  assign WriteCount     = count_reg;

endmodule

// File: tb/tb_wb_stage.sv
module tb_wb_stage;

  localparam int CW = 8;

  logic          Clk = 1'b0;
  logic          Rst_n;
  logic          RegWriteIn, MoveNotZeroIn, DontMoveIn, HiOrLoIn;
  logic          MemToRegIn, HiLoToRegIn;
  logic [1:0]    HiLoWriteIn;
  logic [31:0]   RHiIn, RLoIn, ZeroIn, ALUResultIn, ReadDataIn;
  logic [4:0]    WriteAddressIn, RsAddr, RtAddr;
  logic          RFWriteEnable;
  logic [4:0]    RFWriteAddress;
  logic [31:0]   RFWriteData, HiOut, LoOut, RsData, RtData;
  logic          RsHit, RtHit;
  logic [CW-1:0] WriteCount;

  int checks = 0;
  int errors = 0;
  logic [CW-1:0] exp_cnt;

  always #5 Clk = ~Clk;

  wb_stage #(.CountWidth(CW)) dut (
    .Clk(Clk), .Rst_n(Rst_n),
    .RegWriteIn(RegWriteIn), .MoveNotZeroIn(MoveNotZeroIn),
    .DontMoveIn(DontMoveIn), .HiOrLoIn(HiOrLoIn),
    .MemToRegIn(MemToRegIn), .HiLoToRegIn(HiLoToRegIn),
    .HiLoWriteIn(HiLoWriteIn), .RHiIn(RHiIn), .RLoIn(RLoIn),
    .ZeroIn(ZeroIn), .ALUResultIn(ALUResultIn), .ReadDataIn(ReadDataIn),
    .WriteAddressIn(WriteAddressIn), .RsAddr(RsAddr), .RtAddr(RtAddr),
    .RFWriteEnable(RFWriteEnable), .RFWriteAddress(RFWriteAddress),
    .RFWriteData(RFWriteData), .HiOut(HiOut), .LoOut(LoOut),
    .RsHit(RsHit), .RtHit(RtHit), .RsData(RsData), .RtData(RtData),
    .WriteCount(WriteCount)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, obs);
    end
  endtask

  task automatic clear_in;
    RegWriteIn = 1'b0; MoveNotZeroIn = 1'b0; DontMoveIn = 1'b1;
    HiOrLoIn = 1'b0; MemToRegIn = 1'b0; HiLoToRegIn = 1'b0;
    HiLoWriteIn = 2'b00; RHiIn = '0; RLoIn = '0; ZeroIn = '0;
    ALUResultIn = '0; ReadDataIn = '0; WriteAddressIn = '0;
  endtask

  // Inputs change on the negedge, like the MEM/WB register, then the
  // outputs are sampled 1 ns after the following posedge.
  task automatic setup;
    @(negedge Clk);
    clear_in();
  endtask

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    setup();
    RegWriteIn = 1'b1; WriteAddressIn = a; ALUResultIn = d;
    tick();
  endtask

  initial begin
    clear_in();
    RsAddr = '0; RtAddr = '0;
    Rst_n = 1'b0;
    #12;
    check("rst_en",   32'(RFWriteEnable), 32'd0);
    check("rst_addr", 32'(RFWriteAddress), 32'd0);
    check("rst_data", RFWriteData, 32'd0);
    check("rst_hi",   HiOut, 32'd0);
    check("rst_lo",   LoOut, 32'd0);
    check("rst_cnt",  32'(WriteCount), 32'd0);
    @(negedge Clk);
    Rst_n = 1'b1;

    // Plain ALU write
    wr(5'd5, 32'h1234);
    check("alu_en",   32'(RFWriteEnable), 32'd1);
    check("alu_addr", 32'(RFWriteAddress), 32'd5);
    check("alu_data", RFWriteData, 32'h1234);
    check("alu_cnt",  32'(WriteCount), 32'd1);
    RsAddr = 5'd5; #1;
    check("alu_rshit",  32'(RsHit), 32'd1);
    check("alu_rsdata", RsData, 32'h1234);

    // MOVZ, rt == 0: commits
    setup();
    RegWriteIn = 1'b1; DontMoveIn = 1'b0; MoveNotZeroIn = 1'b0;
    ZeroIn = 32'd0; WriteAddressIn = 5'd6; ALUResultIn = 32'h66;
    tick();
    check("movz0_en",   32'(RFWriteEnable), 32'd1);
    check("movz0_data", RFWriteData, 32'h66);
    check("movz0_cnt",  32'(WriteCount), 32'd2);

    // MOVZ, rt != 0: suppressed, outputs and history hold
    setup();
    RegWriteIn = 1'b1; DontMoveIn = 1'b0; MoveNotZeroIn = 1'b0;
    ZeroIn = 32'd7; WriteAddressIn = 5'd10; ALUResultIn = 32'h77;
    tick();
    check("movz7_en",   32'(RFWriteEnable), 32'd0);
    check("movz7_addr", 32'(RFWriteAddress), 32'd6);
    check("movz7_data", RFWriteData, 32'h66);
    check("movz7_cnt",  32'(WriteCount), 32'd2);
    RsAddr = 5'd10; RtAddr = 5'd5; #1;
    check("movz7_rshit",  32'(RsHit), 32'd0);
    check("movz7_rtdata", RtData, 32'h1234);
    RsAddr = 5'd6; #1;
    check("movz7_rsdata", RsData, 32'h66);

    // MOVN, rt != 0: commits
    setup();
    RegWriteIn = 1'b1; DontMoveIn = 1'b0; MoveNotZeroIn = 1'b1;
    ZeroIn = 32'd7; WriteAddressIn = 5'd9; ALUResultIn = 32'hAA;
    tick();
    check("movn_en",   32'(RFWriteEnable), 32'd1);
    check("movn_addr", 32'(RFWriteAddress), 32'd9);
    check("movn_data", RFWriteData, 32'hAA);

    // MOVN, rt == 0: suppressed
    setup();
    RegWriteIn = 1'b1; DontMoveIn = 1'b0; MoveNotZeroIn = 1'b1;
    ZeroIn = 32'd0; WriteAddressIn = 5'd14; ALUResultIn = 32'hBB;
    tick();
    check("movn0_en", 32'(RFWriteEnable), 32'd0);

    // mfhi in the same cycle as a HI/LO load: old HI is written
    setup();
    RegWriteIn = 1'b1; HiLoToRegIn = 1'b1; HiOrLoIn = 1'b1;
    HiLoWriteIn = 2'b11; RHiIn = 32'hDEAD; RLoIn = 32'hBEEF;
    WriteAddressIn = 5'd3; ALUResultIn = 32'h3333;
    tick();
    check("mthi_data", RFWriteData, 32'h0);
    check("mthi_hi",   HiOut, 32'hDEAD);
    check("mthi_lo",   LoOut, 32'hBEEF);
    check("mthi_cnt",  32'(WriteCount), 32'd4);

    // mfhi while loading LO only
    setup();
    RegWriteIn = 1'b1; HiLoToRegIn = 1'b1; HiOrLoIn = 1'b1;
    HiLoWriteIn = 2'b01; RHiIn = 32'h9999; RLoIn = 32'h1111;
    WriteAddressIn = 5'd4;
    tick();
    check("mfhi_data", RFWriteData, 32'hDEAD);
    check("mfhi_hi",   HiOut, 32'hDEAD);
    check("mfhi_lo",   LoOut, 32'h1111);

    // mflo, HiLoToReg overrides MemToReg
    setup();
    RegWriteIn = 1'b1; HiLoToRegIn = 1'b1; HiOrLoIn = 1'b0;
    MemToRegIn = 1'b1; ReadDataIn = 32'h4444; WriteAddressIn = 5'd11;
    tick();
    check("mflo_data", RFWriteData, 32'h1111);
    check("mflo_cnt",  32'(WriteCount), 32'd6);

    // Load to $0: never committed
    setup();
    RegWriteIn = 1'b1; MemToRegIn = 1'b1; ReadDataIn = 32'h55;
    WriteAddressIn = 5'd0;
    tick();
    check("r0_en",  32'(RFWriteEnable), 32'd0);
    check("r0_cnt", 32'(WriteCount), 32'd6);
    RsAddr = 5'd0; #1;
    check("r0_rshit", 32'(RsHit), 32'd0);

    // Load to a real register: memory data chosen over ALU result
    setup();
    RegWriteIn = 1'b1; MemToRegIn = 1'b1; ReadDataIn = 32'h55;
    ALUResultIn = 32'h99; WriteAddressIn = 5'd12;
    tick();
    check("ld_data", RFWriteData, 32'h55);

    // RegWriteIn low: no commit
    setup();
    WriteAddressIn = 5'd13; ALUResultIn = 32'h13;
    tick();
    check("nowr_en",  32'(RFWriteEnable), 32'd0);
    check("nowr_cnt", 32'(WriteCount), 32'd7);

    // Back-to-back writes to the same register: newest wins
    wr(5'd7, 32'd1);
    wr(5'd7, 32'd2);
    wr(5'd7, 32'd3);
    RsAddr = 5'd7; #1;
    check("b2b_rshit",  32'(RsHit), 32'd1);
    check("b2b_rsdata", RsData, 32'd3);
    wr(5'd8, 32'd8);
    RtAddr = 5'd7; #1;
    check("e1_rthit",  32'(RtHit), 32'd1);
    check("e1_rtdata", RtData, 32'd3);
    wr(5'd9, 32'd9);
    #1;
    check("aged_rthit",  32'(RtHit), 32'd0);
    check("aged_rtdata", RtData, 32'd0);
    check("hist_cnt", 32'(WriteCount), 32'd12);

    // Counter wrap
    exp_cnt = 8'd12;
    while (exp_cnt != 8'hFF) begin
      wr(5'd15, 32'(exp_cnt));
      exp_cnt = exp_cnt + 8'd1;
    end
    check("cnt_full", 32'(WriteCount), 32'hFF);
    wr(5'd16, 32'h16);
    check("cnt_wrap", 32'(WriteCount), 32'd0);

    // Asynchronous reset in the middle of operation
    wr(5'd20, 32'hCAFE);
    check("pre_rst_en", 32'(RFWriteEnable), 32'd1);
    RsAddr = 5'd20; #2;
    Rst_n = 1'b0; #1;
    check("arst_en",    32'(RFWriteEnable), 32'd0);
    check("arst_addr",  32'(RFWriteAddress), 32'd0);
    check("arst_data",  RFWriteData, 32'd0);
    check("arst_hi",    HiOut, 32'd0);
    check("arst_lo",    LoOut, 32'd0);
    check("arst_cnt",   32'(WriteCount), 32'd0);
    check("arst_rshit", 32'(RsHit), 32'd0);
    check("arst_rsdata", RsData, 32'd0);
    setup();
    Rst_n = 1'b1;
    tick();
    check("post_rst_en", 32'(RFWriteEnable), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
# wb_stage

Writeback stage of the five-stage MIPS pipeline, on the consumer side of the MEM/WB pipeline register. Each cycle it takes that register's control and data outputs and resolves the register-file write. This covers the MemToReg, HI/LO and conditional-move (MOVN/MOVZ) selection. It also owns the architectural HI/LO registers and keeps a two-entry history of committed writes that the decode stage uses for forwarding.

## Interface
Parameters:
- CountWidth, 16, width of the committed-write counter

Ports:
- Clk  in  1  pipeline clock; all state updates on posedge
- Rst_n  in  1  asynchronous, active-low reset
- RegWriteIn  in  1  instruction writes a GPR
- MoveNotZeroIn  in  1  conditional move type: 1 = MOVN, 0 = MOVZ
- DontMoveIn  in  1  1 = not a conditional move (write gated by RegWriteIn only)
- HiOrLoIn  in  1  mfhi/mflo source: 1 = HI, 0 = LO
- MemToRegIn  in  1  write data = ReadDataIn
- HiLoToRegIn  in  1  write data = HI or LO register (overrides MemToRegIn)
- HiLoWriteIn  in  2  bit1 = load HI from RHiIn, bit0 = load LO from RLoIn
- RHiIn, RLoIn  in  32 each  new HI/LO values
- ZeroIn  in  32  rt value tested by MOVN/MOVZ
- ALUResultIn  in  32  ALU result
- ReadDataIn  in  32  data-memory load data
- WriteAddressIn  in  5  destination GPR
- RsAddr, RtAddr  in  5 each  decode-stage source addresses for forwarding lookup
- RFWriteEnable  out  1  register-file write strobe (registered)
- RFWriteAddress  out  5  register-file write address (registered)
- RFWriteData  out  32  register-file write data (registered)
- HiOut, LoOut  out  32 each  architectural HI/LO
- RsHit, RtHit  out  1 each  source matches a recent committed write (combinational)
- RsData, RtData  out  32 each  forwarded value; 0 when no hit
- WriteCount  out  CountWidth  number of committed GPR writes, wraps

## Operation
- Data select, priority order:
  - HiLoToRegIn → (HiOrLoIn ? HiOut : LoOut), using the register values before this posedge.
  - else MemToRegIn → ReadDataIn.
  - else ALUResultIn.
- Write condition:
  - Base: Commit = RegWriteIn & (WriteAddressIn != 0) & MoveOk.
  - MoveOk = 1 when DontMoveIn = 1.
  - Otherwise MoveOk = MoveNotZeroIn ? (ZeroIn != 0) : (ZeroIn == 0).
- At each posedge:
  - RFWriteEnable <= Commit.
  - RFWriteAddress and RFWriteData are loaded only when Commit = 1 and hold otherwise.
- HI/LO registers:
  - At the posedge, HiOut <= RHiIn when HiLoWriteIn[1] = 1, and LoOut <= RLoIn when HiLoWriteIn[0] = 1.
  - These updates are independent of Commit.
- History: two entries, E0 (newest) and E1, each holding {valid, addr, data}.
  - On Commit: E1 <= E0, then E0 <= {1, WriteAddressIn, selected data}.
  - With no Commit: the history holds.
- Forwarding lookup (combinational), for each of Rs and Rt:
  - Hit = (addr != 0) & ((E0.valid & E0.addr == addr) | (E1.valid & E1.addr == addr)).
  - E0 has priority over E1.
  - Data = data of the matching entry, or 0 when there is no hit.
- WriteCount increments by 1 on each Commit and wraps from all-ones to 0.

## Timing
- Reset (Rst_n = 0, asynchronous) sets the following, and outputs hold these values while Rst_n = 0:
  - RFWriteEnable = 0, RFWriteAddress = 0, RFWriteData = 0.
  - HiOut = 0, LoOut = 0.
  - Both history entries invalid, with addr = 0 and data = 0.
  - WriteCount = 0.
- Reset assertion mid-operation discards any pending write immediately; no write is issued after release until the next Commit.
- Latency:
  - Inputs are sampled at posedge N. RF outputs and HI/LO are valid after posedge N, and the register file writes them at posedge N+1.
  - Forwarding outputs reflect history updated at posedge N in the same cycle (after N).
- MEM_WB updates on negedge, so inputs are stable for half a cycle before the sampling posedge.
- Simultaneous HiLoWriteIn and HiLoToRegIn in one cycle: the selected data uses the old HI/LO; the new value is visible from the next cycle.
- Back-to-back commits to the same address: E0 and E1 both match; E0 (the newer write) wins.
- A write to $0 is never committed: no history entry is created and WriteCount is unchanged.

## Test plan
- Reset, then RegWriteIn = 1, DontMoveIn = 1, WriteAddressIn = 5, ALUResultIn = 0x1234 → after the posedge: RFWriteEnable = 1, RFWriteAddress = 5, RFWriteData = 0x1234, WriteCount = 1, RsAddr = 5 gives RsHit = 1 and RsData = 0x1234.
- MOVZ with ZeroIn = 0 → commit. MOVZ with ZeroIn = 7 → RFWriteEnable = 0 and history unchanged. MOVN with ZeroIn = 7, WriteAddressIn = 9, data 0xAA → commit.
- HiLoWriteIn = 2'b11, RHiIn = 0xDEAD, RLoIn = 0xBEEF in the same cycle as HiLoToRegIn = 1, HiOrLoIn = 1, addr 3 → RFWriteData = old HI (0 after reset) and HiOut = 0xDEAD. Next cycle, mfhi to addr 4 → RFWriteData = 0xDEAD.
- MemToRegIn = 1, ReadDataIn = 0x55, addr 0 → RFWriteEnable = 0, WriteCount unchanged, lookup on address 0 gives RsHit = 0.
- Commits to addr 7 with data 1, 2, 3 on consecutive cycles → RsData = 3. Then RtAddr = 7 after a write to addr 8 → RtData = 3 (from E1). One more write to addr 9 → lookup on 7 gives RtHit = 0.
- Preload WriteCount to all-ones via 2^CountWidth − 1 commits, commit once more → WriteCount = 0. Assert Rst_n mid-stream → all outputs 0 asynchronously.
